game_state_ctrl: RTL and testbench
==================================

Name: game_state_ctrl

Overview:
- Top-level game sequencer on clk_run.
- Consumes crash events from the enemy/bullet/player crash logic and the frame sync.
- Drives the enable that gates enemy_top and the player/bullet movers.
- Tracks lives, BCD score, post-hit invulnerability and game-over for the HUD and VGA compositor.

Parameters:
- LIVES_INIT, 3, lives loaded on start; 1..7.
- INVULN_FRAMES, 120, frames of invulnerability after a player hit; 1..255.
- SCORE_DIGITS, 4, number of BCD digits in score_o.
- BLINK_SHIFT, 3, invuln_blink_o toggles every 2^BLINK_SHIFT frames.

Ports:
- clk_run  in  1  system run clock.
- rst  in  1  asynchronous active-high reset.
- start_i  in  1  level start/restart request, already debounced and synchronised to clk_run.
- v_sync_i  in  1  VGA vertical sync, synchronised to clk_run.
- crash_me_enemy_i  in  1  player/enemy overlap level, synchronised to clk_run.
- crash_enemy_bullet_i  in  1  bullet/enemy overlap level, synchronised to clk_run.
- en_o  out  1  game-running enable to enemy_top.en_i and the movers.
- invuln_o  out  1  player is invulnerable.
- invuln_blink_o  out  1  player-sprite visibility during invulnerability.
- lives_o  out  3  remaining lives.
- score_o  out  4*SCORE_DIGITS  packed BCD score, digit 0 in the LSBs.
- game_over_o  out  1  game ended, waiting for restart.

Behaviour:
- Interface: one clock (clk_run); reset is asynchronous and active-high (rst).
- Reset values: state IDLE, en_o=0, invuln_o=0, invuln_blink_o=1, lives_o=0, score_o=0, game_over_o=0. All edge-detect registers clear.
- Frame tick: one-cycle pulse on a rising edge of v_sync_i, using a registered previous value that resets to 0.
- Hit and kill events are rising edges of crash_me_enemy_i and crash_enemy_bullet_i. Previous-value registers reset to 0.
- States are IDLE, RUN, HIT, OVER. All outputs are registered; every state change and counter update takes effect on the cycle after the triggering event.
- IDLE: en_o=0. On a start_i rising edge go to RUN, load lives_o=LIVES_INIT, clear score_o.
- RUN: en_o=1, invuln_o=0.
  - On a hit with lives_o>1: decrement lives_o, load the frame counter with INVULN_FRAMES, go to HIT.
  - On a hit with lives_o==1: set lives_o=0, go to OVER.
- HIT: en_o=1, invuln_o=1.
  - Hit edges are ignored.
  - Each frame tick decrements the frame counter. When it reaches 0 on a tick, go to RUN.
  - invuln_blink_o = bit BLINK_SHIFT of the frame counter. It is 1 in every other state.
- OVER: en_o=0, game_over_o=1. lives_o holds 0 and score_o holds its value. On a start_i rising edge, behave exactly as from IDLE and clear game_over_o.
- Score:
  - Each kill edge in RUN or HIT adds 1 as a BCD increment: a digit at 9 wraps to 0 and carries to the next digit.
  - At all-nines the score saturates and does not wrap to 0.
  - Kills in IDLE or OVER are ignored.
- Simultaneous kill and hit in the same cycle: the kill is scored first. In RUN the hit then applies, so a final-life hit plus a kill yields OVER with the score incremented.
- start_i rising edge while in RUN or HIT: ignored.
- A crash level held across many cycles counts once. It must fall before it can count again.
- Reset asserted mid-game: immediate return to reset values, no waiting for a clock edge.

Decomposition:
- Shared header define.v gains:
  - `LIVES_WIDTH (3)
  - `SCORE_DIGITS (4)
  - `SCORE_WIDTH (16)
  - the state encodings `GS_IDLE, `GS_RUN, `GS_HIT, `GS_OVER (2-bit)
- One sub-module, bcd_inc_sat: a combinational SCORE_DIGITS-digit BCD +1 with all-nines saturation. It is instantiated once; the score register stays in game_state_ctrl.

Test Plan:
- Reset then start_i pulse → next cycle state RUN, en_o=1, lives_o=3, score_o=16'h0000. With rst held high: all outputs at reset values.
- In RUN, 12 kill edges with crash_enemy_bullet_i high 5 cycles each → score_o=16'h0012. Preload via 9999 kill edges → 16'h9999, and one more edge → still 16'h9999.
- Hit in RUN with lives 3 → lives_o=2, invuln_o=1. Hit edges during the 120 frame ticks leave lives_o=2. On the 120th tick → RUN, invuln_o=0. invuln_blink_o toggles every 8 ticks.
- Three separated hits → lives 2, 1, then 0 with game_over_o=1, en_o=0. Kill edges in OVER leave score_o unchanged. start_i → RUN, lives 3, score 0, game_over_o=0.
- Kill and hit in the same cycle on the last life → OVER with score_o incremented by 1.
- rst asserted asynchronously during HIT → outputs at reset values before the next clk_run edge. After release, start_i is required before en_o rises.

Source files
------------

// File: rtl/game_state_ctrl_pkg.sv
// Shared widths, state encoding and small helpers for the game sequencer.
package game_state_ctrl_pkg;

  localparam int LIVES_W          = 3;
  localparam int SCORE_DIGITS_DEF = 4;
  localparam int SCORE_W          = 4 * SCORE_DIGITS_DEF;
  localparam int FRAME_CNT_W      = 8;

  typedef enum logic [1:0] {
    GS_IDLE = 2'd0,
    GS_RUN  = 2'd1,
    GS_HIT  = 2'd2,
    GS_OVER = 2'd3
  } gs_state_t;

  function automatic logic bcd_is_nine(input logic [3:0] digit);
    return digit == 4'd9;
  endfunction

endpackage

// File: rtl/bcd_inc_sat.sv
// Purpose: multi-digit packed BCD +1 that sticks at all-nines.
// Latency: combinational.
// Backpressure: none, pure function of the input.
module bcd_inc_sat
  import game_state_ctrl_pkg::*;
#(
  parameter int DIGITS = SCORE_DIGITS_DEF
) (
  input  logic [4*DIGITS-1:0] val_i,
  output logic [4*DIGITS-1:0] inc_o
);

  logic       carry;
  logic       all_nines;
  logic [3:0] digit;

  always_comb begin
    inc_o     = val_i;
    carry     = 1'b1;
    all_nines = 1'b1;
    digit     = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      digit = val_i[4*d +: 4];
      if (!bcd_is_nine(digit)) all_nines = 1'b0;
      if (carry) begin
        if (bcd_is_nine(digit)) begin
          inc_o[4*d +: 4] = 4'd0;
        end else begin
          inc_o[4*d +: 4] = digit + 4'd1;
          carry           = 1'b0;
        end
      end
    end
    // Saturate rather than roll the score over to zero.
    if (all_nines) inc_o = val_i;
  end

endmodule

// File: rtl/game_state_ctrl.sv
// Purpose: game sequencer - lives, BCD score, post-hit invulnerability, game over.
// Latency: every event (edge of start/crash/vsync) is reflected one clk_run later.
// Backpressure: none; inputs are levels, only their rising edges are acted upon.
module game_state_ctrl
  import game_state_ctrl_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int INVULN_FRAMES = 120,
  parameter int SCORE_DIGITS  = SCORE_DIGITS_DEF,
  parameter int BLINK_SHIFT   = 3
) (
  input  logic                      clk_run,
  input  logic                      rst,
  input  logic                      start_i,
  input  logic                      v_sync_i,
  input  logic                      crash_me_enemy_i,
  input  logic                      crash_enemy_bullet_i,
  output logic                      en_o,
  output logic                      invuln_o,
  output logic                      invuln_blink_o,
  output logic [LIVES_W-1:0]        lives_o,
  output logic [4*SCORE_DIGITS-1:0] score_o,
  output logic                      game_over_o
);

  localparam logic [LIVES_W-1:0]     LIVES_LD  = LIVES_W'(LIVES_INIT);
  localparam logic [FRAME_CNT_W-1:0] INVULN_LD = FRAME_CNT_W'(INVULN_FRAMES);

  gs_state_t                state;
  logic                     start_q, vs_q, me_q, kill_q;
  logic [FRAME_CNT_W-1:0]   frame_cnt;
  logic [FRAME_CNT_W-1:0]   frame_dec;
  logic [4*SCORE_DIGITS-1:0] score_inc;
  logic                     start_edge, tick, hit_edge, kill_edge;

  assign start_edge = start_i & ~start_q;
  assign tick       = v_sync_i & ~vs_q;
  assign hit_edge   = crash_me_enemy_i & ~me_q;
  assign kill_edge  = crash_enemy_bullet_i & ~kill_q;
  assign frame_dec  = frame_cnt - FRAME_CNT_W'(1);

  bcd_inc_sat #(.DIGITS(SCORE_DIGITS)) u_bcd_inc (
    .val_i (score_o),
    .inc_o (score_inc)
  );

  always_ff @(posedge clk_run or posedge rst) begin
    if (rst) begin
      state          <= GS_IDLE;
      en_o           <= 1'b0;
      invuln_o       <= 1'b0;
      invuln_blink_o <= 1'b1;
      lives_o        <= '0;
      score_o        <= '0;
      game_over_o    <= 1'b0;
      frame_cnt      <= '0;
      start_q        <= 1'b0;
      vs_q           <= 1'b0;
      me_q           <= 1'b0;
      kill_q         <= 1'b0;
    end else begin
      start_q <= start_i;
      vs_q    <= v_sync_i;
      me_q    <= crash_me_enemy_i;
      kill_q  <= crash_enemy_bullet_i;

      // Kill is scored before any hit in the same cycle is applied below.
      if (kill_edge && (state == GS_RUN || state == GS_HIT)) score_o <= score_inc;

      case (state)
        GS_IDLE, GS_OVER: begin
          if (start_edge) begin
            state          <= GS_RUN;
            en_o           <= 1'b1;
            invuln_o       <= 1'b0;
            invuln_blink_o <= 1'b1;
            lives_o        <= LIVES_LD;
            score_o        <= '0;
            game_over_o    <= 1'b0;
          end
        end
        GS_RUN: begin
          if (hit_edge) begin
            if (lives_o > LIVES_W'(1)) begin
              lives_o        <= lives_o - LIVES_W'(1);
              frame_cnt      <= INVULN_LD;
              state          <= GS_HIT;
              invuln_o       <= 1'b1;
              invuln_blink_o <= INVULN_LD[BLINK_SHIFT];
            end else begin
              lives_o     <= '0;
              state       <= GS_OVER;
              en_o        <= 1'b0;
              game_over_o <= 1'b1;
            end
          end
        end
        GS_HIT: begin
          if (tick) begin
            frame_cnt <= frame_dec;
            if (frame_dec == '0) begin
              state          <= GS_RUN;
              invuln_o       <= 1'b0;
              invuln_blink_o <= 1'b1;
            end else begin
              invuln_blink_o <= frame_dec[BLINK_SHIFT];
            end
          end
        end
        default: state <= GS_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_state_ctrl.sv
// Scoreboarded bench for game_state_ctrl: a cycle model predicts outputs per driven cycle.
module tb_game_state_ctrl;
  import game_state_ctrl_pkg::*;

  logic               clk_run = 1'b0;
  logic               rst;
  logic               start_i, v_sync_i, crash_me_enemy_i, crash_enemy_bullet_i;
  logic               en_o, invuln_o, invuln_blink_o, game_over_o;
  logic [LIVES_W-1:0] lives_o;
  logic [SCORE_W-1:0] score_o;

  game_state_ctrl dut (
    .clk_run              (clk_run),
    .rst                  (rst),
    .start_i              (start_i),
    .v_sync_i             (v_sync_i),
    .crash_me_enemy_i     (crash_me_enemy_i),
    .crash_enemy_bullet_i (crash_enemy_bullet_i),
    .en_o                 (en_o),
    .invuln_o             (invuln_o),
    .invuln_blink_o       (invuln_blink_o),
    .lives_o              (lives_o),
    .score_o              (score_o),
    .game_over_o          (game_over_o)
  );

  always #5 clk_run = ~clk_run;

  typedef struct packed {
    logic               en;
    logic               inv;
    logic               blink;
    logic [LIVES_W-1:0] lives;
    logic [SCORE_W-1:0] score;
    logic               go;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model state
  gs_state_t m_st;
  int        m_lives, m_score, m_cnt;
  logic      p_s, p_v, p_m, p_k;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [SCORE_W-1:0] to_bcd(input int n);
    logic [SCORE_W-1:0] r;
    r = '0;
    for (int d = 0; d < SCORE_W / 4; d++) begin
      r[4*d +: 4] = 4'(n % 10);
      n = n / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_st = GS_IDLE; m_lives = 0; m_score = 0; m_cnt = 0;
    p_s = 0; p_v = 0; p_m = 0; p_k = 0;
  endtask

  task automatic model_step(input logic s, input logic v, input logic m, input logic k);
    logic se, te, he, ke;
    exp_t e;
    se = s & ~p_s; te = v & ~p_v; he = m & ~p_m; ke = k & ~p_k;
    p_s = s; p_v = v; p_m = m; p_k = k;
    if (ke && (m_st == GS_RUN || m_st == GS_HIT) && m_score < 9999) m_score++;
    case (m_st)
      GS_IDLE, GS_OVER: if (se) begin m_st = GS_RUN; m_lives = 3; m_score = 0; end
      GS_RUN: if (he) begin
        if (m_lives > 1) begin m_lives--; m_cnt = 120; m_st = GS_HIT; end
        else begin m_lives = 0; m_st = GS_OVER; end
      end
      GS_HIT: if (te) begin
        m_cnt--;
        if (m_cnt == 0) m_st = GS_RUN;
      end
      default: ;
    endcase
    e.en    = (m_st == GS_RUN) || (m_st == GS_HIT);
    e.inv   = (m_st == GS_HIT);
    e.blink = (m_st == GS_HIT) ? ((m_cnt / 8) % 2 == 1) : 1'b1;
    e.lives = 3'(m_lives);
    e.score = to_bcd(m_score);
    e.go    = (m_st == GS_OVER);
    sb.push_back(e);
  endtask

  task automatic cyc(input logic s, input logic v, input logic m, input logic k);
    exp_t e;
    @(negedge clk_run);
    start_i = s; v_sync_i = v; crash_me_enemy_i = m; crash_enemy_bullet_i = k;
    model_step(s, v, m, k);
    @(posedge clk_run);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      chk("en",     32'(en_o),           32'(e.en));
      chk("invuln", 32'(invuln_o),       32'(e.inv));
      chk("blink",  32'(invuln_blink_o), 32'(e.blink));
      chk("lives",  32'(lives_o),        32'(e.lives));
      chk("score",  32'(score_o),        32'(e.score));
      chk("gover",  32'(game_over_o),    32'(e.go));
    end
  endtask

  task automatic kill(input int hi);
    for (int i = 0; i < hi; i++) cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 0);
  endtask

  task automatic hit(input int hi);
    for (int i = 0; i < hi; i++) cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(0, 1, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_en"},    32'(en_o),           32'd0);
    chk({tag, "_inv"},   32'(invuln_o),       32'd0);
    chk({tag, "_blink"}, 32'(invuln_blink_o), 32'd1);
    chk({tag, "_lives"}, 32'(lives_o),        32'd0);
    chk({tag, "_score"}, 32'(score_o),        32'd0);
    chk({tag, "_gover"}, 32'(game_over_o),    32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start_i = 0; v_sync_i = 0; crash_me_enemy_i = 0; crash_enemy_bullet_i = 0;
    model_reset();
    repeat (2) @(posedge clk_run);
    #1 chk_reset_vals("rst");
    start_i = 1'b1;
    @(posedge clk_run);
    #1 chk_reset_vals("rst_start");
    start_i = 1'b0;
    @(negedge clk_run);
    rst = 1'b0;

    // Idle, then start
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("start_en", 32'(en_o), 32'd1);
    chk("start_lives", 32'(lives_o), 32'd3);
    chk("start_score", 32'(score_o), 32'h0000);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // 12 kills, level held 5 cycles each
    for (int i = 0; i < 12; i++) kill(5);
    chk("score12", 32'(score_o), 32'h0012);

    // First hit with invulnerability window and ignored hits
    hit(3);
    chk("hit1_lives", 32'(lives_o), 32'd2);
    chk("hit1_inv", 32'(invuln_o), 32'd1);
    chk("hit1_blink", 32'(invuln_blink_o), 32'd1);
    frames(1);
    chk("blink_t1", 32'(invuln_blink_o), 32'd0);
    for (int i = 0; i < 3; i++) begin
      hit(2);
      frames(1);
    end
    frames(4);
    chk("blink_t8", 32'(invuln_blink_o), 32'd0);
    frames(1);
    chk("blink_t9", 32'(invuln_blink_o), 32'd1);
    chk("hit_ignored", 32'(lives_o), 32'd2);
    frames(110);
    chk("t119_inv", 32'(invuln_o), 32'd1);
    frames(1);
    chk("t120_inv", 32'(invuln_o), 32'd0);
    chk("t120_en", 32'(en_o), 32'd1);
    chk("t120_lives", 32'(lives_o), 32'd2);

    // Second hit, then final hit coinciding with a kill
    hit(1);
    chk("hit2_lives", 32'(lives_o), 32'd1);
    frames(120);
    cyc(0, 0, 1, 1);
    cyc(0, 0, 0, 0);
    chk("over_gover", 32'(game_over_o), 32'd1);
    chk("over_en", 32'(en_o), 32'd0);
    chk("over_lives", 32'(lives_o), 32'd0);
    chk("over_score", 32'(score_o), 32'h0013);
    for (int i = 0; i < 3; i++) kill(2);
    chk("over_kills", 32'(score_o), 32'h0013);

    // Restart
    cyc(1, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("restart_lives", 32'(lives_o), 32'd3);
    chk("restart_score", 32'(score_o), 32'h0000);
    chk("restart_gover", 32'(game_over_o), 32'd0);
    chk("restart_en", 32'(en_o), 32'd1);

    // Saturation
    while (m_score < 9999) kill(1);
    chk("sat_9999", 32'(score_o), 32'h9999);
    kill(1);
    chk("sat_hold", 32'(score_o), 32'h9999);

    // Async reset during HIT
    hit(1);
    frames(3);
    chk("pre_rst_inv", 32'(invuln_o), 32'd1);
    #1 rst = 1'b1;
    #1 chk_reset_vals("async");
    model_reset();
    @(posedge clk_run);
    @(negedge clk_run);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0);
    chk("post_rst_en", 32'(en_o), 32'd0);
    cyc(1, 0, 0, 0);
    chk("post_rst_start_en", 32'(en_o), 32'd1);
    cyc(0, 0, 0, 0);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
